// File: rtl/i2c_slave_regs_pkg.sv
// Shared I2C definitions: slave FSM state encoding, ACK/NACK bus levels,
// R/W bit values (identical to those used by the sa9226 master) and a
// device-address compare helper.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV_ADDR  = 4'd1,
    ST_DEV_ACK   = 4'd2,
    ST_REG_ADDR  = 4'd3,
    ST_REG_ACK   = 4'd4,
    ST_WR_DATA   = 4'd5,
    ST_WR_ACK    = 4'd6,
    ST_RD_DATA   = 4'd7,
    ST_RD_ACK    = 4'd8,
    ST_WAIT_STOP = 4'd9
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic I2C_WR   = 1'b0;
  localparam logic I2C_RD   = 1'b1;

  // True when the address byte (addr[7:1], R/W in bit 0) selects dev_addr.
  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [6:0] dev_addr);
    return (addr_byte[7:1] == dev_addr);
  endfunction

endpackage

// File: rtl/i2c_slave_regs_line_sync.sv
// SCL/SDA synchronizer with single-cycle SCL edge pulses and START/STOP
// detection. SDA edges are formed internally and qualified with the
// synchronized SCL level to give START (fall) and STOP (rise).
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_hist_q, scl_hist_d;
  logic                   sda_hist_q, sda_hist_d;
  logic                   scl_s;
  logic                   sda_rise;
  logic                   sda_fall;

  // Shift the raw pins through the synchronizer and keep one history sample.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    scl_hist_d = scl_sync_q[SYNC_STAGES-1];
    sda_hist_d = sda_sync_q[SYNC_STAGES-1];
  end

  // Synchronizer registers; reset to the idle (released, high) bus level.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign sda_rise  = sda_s & ~sda_hist_q;
  assign sda_fall  = ~sda_s & sda_hist_q;
  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target exposing a byte-addressed register bank. Supports pointer
// write + data writes (auto-increment) and pointer set + repeated START +
// sequential reads. SDA is driven open-drain through sda_oe and only
// changes after a falling SCL edge.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h57,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  i2c_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_done_q, byte_done_d;   // 8th bit clocked, byte ends on next fall
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rw_q, rw_d;
  logic       mack_q, mack_d;             // master ACK/NACK after a read byte

  // Next-state and datapath: START/STOP first, then per-state bit handling.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = byte_done_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rw_d        = rw_q;
    mack_d      = mack_q;

    if (start_det) begin
      state_d     = ST_DEV_ADDR;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
          if (scl_rise) begin
            shift_d     = {shift_q[6:0], sda_s};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_done_d = (bit_cnt_q == 3'd7);
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            if (state_q == ST_DEV_ADDR) begin
              if (addr_match(shift_q, SLAVE_ADDR)) begin
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                rw_d     = shift_q[0];
                state_d  = ST_DEV_ACK;
              end else begin
                sda_oe_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = ST_WAIT_STOP;
              end
            end else if (state_q == ST_REG_ADDR) begin
              ptr_d    = shift_q;
              sda_oe_d = 1'b1;
              state_d  = ST_REG_ACK;
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = shift_q;
              ptr_d     = ptr_q + 8'd1;
              sda_oe_d  = 1'b1;
              state_d   = ST_WR_ACK;
            end
          end else begin
            state_d = state_q;
          end
        end

        ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            if (state_q == ST_DEV_ACK && rw_q == I2C_RD) begin
              shift_d  = rd_data;
              sda_oe_d = ~rd_data[7];
              ptr_d    = ptr_q + 8'd1;
              state_d  = ST_RD_DATA;
            end else if (state_q == ST_DEV_ACK) begin
              sda_oe_d = 1'b0;
              state_d  = ST_REG_ADDR;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WR_DATA;
            end
          end else begin
            state_d = state_q;
          end
        end

        ST_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_done_d = (bit_cnt_q == 3'd7);
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b0;
            state_d     = ST_RD_ACK;
          end else if (scl_fall) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end else begin
            state_d = state_q;
          end
        end

        ST_RD_ACK: begin
          if (scl_rise) begin
            mack_d = sda_s;
          end else if (scl_fall && mack_q == I2C_ACK) begin
            shift_d     = rd_data;
            sda_oe_d    = ~rd_data[7];
            ptr_d       = ptr_q + 8'd1;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            state_d     = ST_RD_DATA;
          end else if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = ST_WAIT_STOP;
          end else begin
            state_d = state_q;
          end
        end

        ST_IDLE, ST_WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      byte_done_q <= 1'b0;
      shift_q     <= 8'h00;
      ptr_q       <= 8'h00;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
      rw_q        <= I2C_WR;
      mack_q      <= I2C_NACK;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rw_q        <= rw_d;
      mack_q      <= mack_d;
    end
  end

  assign sda_oe  = sda_oe_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_addr = ptr_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bit-banged I2C master driving i2c_slave_regs, with a register-bank stub
// on the local port and a transaction-level memory/pointer model.
module tb_i2c_slave_regs;

  localparam int Q = 5;   // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       scl_i, sda_i;
  logic       sda_oe, wr_en, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

  i2c_slave_regs dut (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Open-drain wired-AND bus.
  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe;

  // Register bank stub.
  logic [7:0] bank [256];
  assign rd_data = bank[rd_addr];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) bank[i] <= 8'h00;
    end else if (wr_en) begin
      bank[wr_addr] <= wr_data;
    end
  end

  // Every clock with wr_en high is logged as one write.
  logic [15:0] wr_log [$];
  always @(posedge clk) begin
    if (!rst && wr_en) wr_log.push_back({wr_addr, wr_data});
  end

  int vectors = 0;
  int miscompares = 0;
  int wr_seen = 0;

  logic [7:0]  model_mem [256];
  logic [7:0]  model_ptr;
  logic [15:0] exp_wr [$];
  logic [7:0]  tx_data [$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic qwait;
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; qwait;
    scl_m = 1'b1; qwait;
    sda_m = 1'b0; qwait;
    scl_m = 1'b0; qwait;
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; qwait;
    scl_m = 1'b1; qwait;
    sda_m = 1'b1; qwait;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; qwait;
    scl_m = 1'b1; qwait; qwait;
    scl_m = 1'b0; qwait;
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; qwait;
    scl_m = 1'b1; qwait;
    b = sda_i; qwait;
    scl_m = 1'b0; qwait;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(mack);
  endtask

  // Compare the DUT's logged writes since last call with the expected list.
  task automatic check_writes(input string tag);
    check({tag, "_count"}, 16'(wr_log.size() - wr_seen), 16'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && wr_seen + i < wr_log.size(); i++)
      check({tag, "_entry"}, wr_log[wr_seen + i], exp_wr[i]);
    wr_seen = wr_log.size();
    exp_wr.delete();
  endtask

  // Pointer write followed by all bytes in tx_data.
  task automatic write_txn(input string tag, input logic [7:0] p);
    logic a;
    i2c_start;
    write_byte(8'hAE, a);
    check({tag, "_devack"}, 16'(a), 16'h0000);
    check({tag, "_busy"}, 16'(busy), 16'h0001);
    write_byte(p, a);
    check({tag, "_regack"}, 16'(a), 16'h0000);
    for (int i = 0; i < tx_data.size(); i++) begin
      write_byte(tx_data[i], a);
      check({tag, "_dataack"}, 16'(a), 16'h0000);
      exp_wr.push_back({p + 8'(i), tx_data[i]});
      model_mem[p + 8'(i)] = tx_data[i];
    end
    model_ptr = p + 8'(tx_data.size());
    i2c_stop;
    qwait;
    check_writes(tag);
    check({tag, "_ptr"}, 16'(rd_addr), 16'(model_ptr));
    check({tag, "_busy_after"}, 16'(busy), 16'h0000);
  endtask

  // Pointer set, repeated START, n sequential reads (last one NACKed).
  task automatic read_txn(input string tag, input logic [7:0] p, input int n);
    logic       a;
    logic [7:0] d;
    i2c_start;
    write_byte(8'hAE, a);
    check({tag, "_devack"}, 16'(a), 16'h0000);
    write_byte(p, a);
    check({tag, "_regack"}, 16'(a), 16'h0000);
    i2c_start;
    write_byte(8'hAF, a);
    check({tag, "_rdack"}, 16'(a), 16'h0000);
    for (int i = 0; i < n; i++) begin
      read_byte((i == n - 1) ? 1'b1 : 1'b0, d);
      check({tag, "_data"}, 16'(d), 16'(model_mem[p + 8'(i)]));
    end
    check({tag, "_released"}, 16'(sda_oe), 16'h0000);
    i2c_stop;
    model_ptr = p + 8'(n);
    qwait;
    check({tag, "_ptr"}, 16'(rd_addr), 16'(model_ptr));
    check_writes(tag);
  endtask

  initial begin
    logic a;
    scl_m = 1'b1;
    sda_m = 1'b1;
    rst   = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    model_ptr = 8'h00;
    repeat (4) @(negedge clk);
    check("rst_sda_oe", 16'(sda_oe), 16'h0000);
    check("rst_wr_en", 16'(wr_en), 16'h0000);
    check("rst_wr_addr", 16'(wr_addr), 16'h0000);
    check("rst_wr_data", 16'(wr_data), 16'h0000);
    check("rst_rd_addr", 16'(rd_addr), 16'h0000);
    check("rst_busy", 16'(busy), 16'h0000);
    rst = 1'b0;
    qwait;

    // Two writes from pointer 0x10.
    tx_data = '{8'h5A, 8'hC3};
    write_txn("wr2", 8'h10);

    // Read them back through a repeated START.
    read_txn("rd2", 8'h10, 2);

    // Foreign address: no ACK, no busy, no write.
    i2c_start;
    write_byte(8'hA0, a);
    check("nomatch_ack", 16'(a), 16'h0001);
    check("nomatch_busy", 16'(busy), 16'h0000);
    write_byte(8'h55, a);
    check("nomatch_ack2", 16'(a), 16'h0001);
    i2c_stop;
    qwait;
    check_writes("nomatch");

    // Pointer wrap.
    tx_data = '{8'h11, 8'h22};
    write_txn("wrap", 8'hFF);

    // STOP in the middle of a data byte.
    i2c_start;
    write_byte(8'hAE, a);
    write_byte(8'h20, a);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop;
    qwait;
    model_ptr = 8'h20;
    check_writes("partial");
    check("partial_busy", 16'(busy), 16'h0000);
    check("partial_sda_oe", 16'(sda_oe), 16'h0000);
    check("partial_ptr", 16'(rd_addr), 16'(model_ptr));
    tx_data = '{8'h77};
    write_txn("after_partial", 8'h20);

    // Randomized write/read traffic.
    for (int it = 0; it < 6; it++) begin
      logic [7:0] p;
      int         n;
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      tx_data.delete();
      for (int k = 0; k < n; k++) tx_data.push_back(8'($urandom_range(0, 255)));
      write_txn("rand_wr", p);
      read_txn("rand_rd", p, n);
      read_txn("rand_rd_any", 8'($urandom_range(0, 255)), $urandom_range(1, 3));
    end

    // Reset while the slave pulls SDA low for a read bit.
    tx_data = '{8'h3C};
    write_txn("pre_rst", 8'h40);
    i2c_start;
    write_byte(8'hAE, a);
    write_byte(8'h40, a);
    i2c_start;
    write_byte(8'hAF, a);
    qwait;
    check("rst_pre_drive", 16'(sda_oe), 16'h0001);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sda_oe", 16'(sda_oe), 16'h0000);
    check("midrst_wr_en", 16'(wr_en), 16'h0000);
    check("midrst_wr_addr", 16'(wr_addr), 16'h0000);
    check("midrst_wr_data", 16'(wr_data), 16'h0000);
    check("midrst_rd_addr", 16'(rd_addr), 16'h0000);
    check("midrst_busy", 16'(busy), 16'h0000);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    model_ptr = 8'h00;
    scl_m = 1'b1; qwait;
    sda_m = 1'b1; qwait;
    wr_seen = wr_log.size();
    tx_data = '{8'h99, 8'h01};
    write_txn("post_rst", 8'h05);
    read_txn("post_rst_rd", 8'h04, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
